// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one fixed-latency data-memory port between two requesters:
//   requester 0 = CPU load/store path (cpu_*)
//   requester 1 = DMA / debug loader  (dma_*)
//
// Each side uses a req/gnt/done handshake. The requester holds req until gnt,
// which is combinational from req while the arbiter is IDLE. The arbiter
// captures the winner's command, runs it on the memory port for LAT cycles,
// and then pulses the winner's done for one cycle. Only one access is in
// flight at a time.
//
// Parameters
//   LAT        : memory read/write latency in cycles (1..256; 0 unsupported)
//   FIXED_PRIO : 1 = CPU always wins, 0 = round-robin (alternates on ties)
//
// Ports
//   clk, rst                      : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/bytes   : CPU command inputs
//   cpu_gnt, cpu_done, cpu_rdata  : CPU grant, completion pulse, load data
//   dma_*                         : same set for the DMA requester
//   mem_en/we/addr/wdata/bytes    : memory command outputs (valid in ACCESS)
//   mem_rdata                     : memory read data, valid LAT cycles after
//                                   mem_en first rises
//   busy                          : high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int unsigned LAT        = 1,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_bytes,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_bytes,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bytes,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  // Counter only has to hold LAT-1; keep at least one bit for LAT == 1.
  localparam int unsigned   CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // owner of the most recent grant
  logic          owner_q, owner_d;   // owner of the access in flight
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    bytes_q, bytes_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;

  logic          win_cpu, win_dma;

  // ---------------------------------------------------------------------------
  // Arbitration: decides who would win if the arbiter were IDLE right now.
  // On a round-robin tie the requester that did not own the last grant wins;
  // last_q resets to 1 so the CPU takes the first tie.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_cpu = 1'b0;
    win_dma = 1'b0;
    if (FIXED_PRIO) begin
      win_cpu = cpu_req;
      win_dma = dma_req & ~cpu_req;
    end else if (cpu_req && dma_req) begin
      win_cpu = last_q;
      win_dma = ~last_q;
    end else begin
      win_cpu = cpu_req;
      win_dma = dma_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: every variable gets its hold value first so that no path through the
  // case statement leaves one unassigned, which would infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bytes_d     = bytes_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (win_cpu || win_dma) begin
          owner_d = win_dma;
          last_d  = win_dma;
          we_d    = win_dma ? dma_we    : cpu_we;
          addr_d  = win_dma ? dma_addr  : cpu_addr;
          wdata_d = win_dma ? dma_wdata : cpu_wdata;
          bytes_d = win_dma ? dma_bytes : cpu_bytes;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Last ACCESS cycle: read data is valid now. Writes leave the
          // owner's rdata untouched; the non-owner's rdata is never touched.
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        // Never arbitrate here: a req still high is seen in the next IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bytes_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bytes_q     <= bytes_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Grants are combinational but gated by rst so every output is 0
  // while reset is held, whatever the requesters are doing.
  // ---------------------------------------------------------------------------
  assign cpu_gnt   = rst && (state_q == S_IDLE) && win_cpu;
  assign dma_gnt   = rst && (state_q == S_IDLE) && win_dma;

  assign cpu_done  = (state_q == S_RESP) && !owner_q;
  assign dma_done  = (state_q == S_RESP) &&  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

  // Memory command comes only from the captured registers, so requester
  // input changes during ACCESS cannot reach the memory.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign mem_bytes = mem_en ? bytes_q : '0;

  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU load/store path (requester 0) and a DMA/debug loader (requester 1).
- Uses a request/grant/done handshake on each requester side.
- Drives a fixed-latency memory on the other side.
- Owns the memory address, write-data, write-enable and byte-lane (iobytes) signals. Serialises accesses one at a time, using round-robin or fixed CPU priority.

Parameters:
- LAT, 1, memory read/write latency in cycles. Legal range is 1..256; 0 is unsupported.
- FIXED_PRIO, 0, selects arbitration. 1 = CPU (requester 0) always wins. 0 = round-robin.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_bytes  in  4  byte-lane enables.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_done  out  1  one-cycle pulse: access complete.
- cpu_rdata  out  32  load data; valid when cpu_done, held afterwards.
- dma_req, dma_we, dma_addr, dma_wdata, dma_bytes, dma_gnt, dma_done, dma_rdata: same directions, widths and meanings as the cpu_* ports, for requester 1.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_bytes  out  4  memory byte lanes (iobytes).
- mem_rdata  in  32  memory read data; valid LAT cycles after mem_en first rises.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, takes effect immediately, no clock needed):
  - State = IDLE; cnt = 0; last = 1, so the CPU wins the first tie.
  - Command registers = 0; cpu_rdata = dma_rdata = 0.
  - All outputs are 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - gnt is combinational from req in the same cycle.
  - Exactly one gnt may be high.
  - FIXED_PRIO=1: cpu_req wins whenever high.
  - FIXED_PRIO=0: a single requester wins. On a tie, the requester other than `last` wins.
  - At the clock edge with a grant:
    - Capture the winner's we/addr/wdata/bytes and owner id.
    - Set last = owner.
    - Set cnt = LAT-1 and go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_we/addr/wdata/bytes are driven from the captured registers and are stable for all LAT cycles.
  - No gnt is asserted; new requests wait.
  - At each edge with cnt != 0, decrement cnt.
  - At the edge with cnt == 0:
    - If the access is a read, latch mem_rdata into the owner's rdata register.
    - Go to RESP.
- RESP:
  - The owner's done = 1 for exactly one cycle; mem_en = 0.
  - Go to IDLE at the next edge.
- Latency: req sampled in cycle 0 (gnt), ACCESS in cycles 1..LAT, done in cycle LAT+1.
- Maximum throughput: one access per LAT+2 cycles.
- Writes: done pulses as the acknowledge; the owner's rdata keeps its previous value.
- The non-owner's rdata is never modified.
- Req deasserted after grant: ignored; the access completes normally.
- Req still high at done: treated as a new request. It is arbitrated in the IDLE cycle that follows RESP, so it is never back-to-back with RESP.
- Requester input changes while in ACCESS have no effect on mem_* outputs.
- Reset asserted mid-ACCESS or in RESP: immediate return to IDLE with mem_en = 0, no done pulse, and rdata cleared.
- Round-robin guarantees that with both requesters held continuously, grants alternate 0,1,0,1…

Test Plan:
- Single CPU read, LAT=1: cpu_req with addr 0x100, memory returns 0xDEADBEEF.
  - Required: cpu_gnt in cycle 0; mem_en high in cycle 1 only with mem_addr=0x100; cpu_done in cycle 2; cpu_rdata=0xDEADBEEF and held.
- DMA write, LAT=3: dma_we=1, addr 0x40, wdata 0x12345678, bytes 4'b0011.
  - Required: mem_en/mem_we high for exactly 3 cycles with stable values; dma_done in cycle 4; dma_rdata unchanged; busy high in cycles 1-4.
- Simultaneous requests held continuously, FIXED_PRIO=0, LAT=1.
  - Required: grant order is cpu, dma, cpu, dma; gnts are never high together; each done goes to the matching owner.
- Same stimulus with FIXED_PRIO=1.
  - Required: CPU is granted every 3 cycles; dma_gnt is never asserted until cpu_req drops, then dma_gnt follows in the next IDLE cycle.
- rst driven low in the 2nd ACCESS cycle with LAT=4.
  - Required: mem_en and busy drop without waiting for a clock edge; no done pulse; after release, a fresh cpu_req is granted with CPU winning the tie.
- cpu_req dropped in the cycle after gnt, and the CPU address changed during ACCESS.
  - Required: the access completes at the original address; cpu_done pulses once; there is no second grant.
